tick_sched: RTL and testbench

TICK_SCHED -- requirements
Module: tick_sched

---
 rtl/mpcd_pkg.sv | 19 +
 rtl/tick_sched_if.sv | 18 +
 rtl/tick_sched_rr_arbiter.sv | 34 +++
 rtl/tick_sched.sv | 110 +++++++++++
 tb/tb_tick_sched.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpcd_pkg.sv
// Shared definitions for the tick-driven timer scheduler: FSM encoding,
// default geometry and a pointer-width helper.
package mpcd_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_sched_if.sv
// Requester-side bundle of the shared timer: tick enable, requests, delays
// and the grant/done/busy responses.
interface tick_sched_if import mpcd_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF
);

  logic                tick;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] dly;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic                busy;

  modport master (output tick, req, dly, input gnt, done, busy);
  modport slave  (input tick, req, dly, output gnt, done, busy);

endinterface

// File: rtl/tick_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping to the lowest set request when none lies at or above ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] sel,
  output logic [PW-1:0]    idx
);

  logic          hi_found_s;
  logic          lo_found_s;
  logic [PW-1:0] hi_idx_s;
  logic [PW-1:0] lo_idx_s;

  // Scan downward so the last hit is the lowest qualifying index.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = {PW{1'b0}};
    lo_idx_s   = {PW{1'b0}};
    for (int i = N_REQ - 1; i >= 0; i--) begin
      lo_found_s = lo_found_s | req[i];
      lo_idx_s   = req[i] ? PW'(i) : lo_idx_s;
      hi_found_s = hi_found_s | (req[i] & (PW'(i) >= ptr));
      hi_idx_s   = (req[i] && (PW'(i) >= ptr)) ? PW'(i) : hi_idx_s;
    end
    idx = hi_found_s ? hi_idx_s : lo_idx_s;
    sel = lo_found_s ? (N_REQ'(1) << idx) : {N_REQ{1'b0}};
  end

endmodule

// File: rtl/tick_sched.sv
// Shares one DW-bit tick down-counter among N_REQ requesters with
// round-robin arbitration, cancel-on-drop and a one-cycle DONE pulse.
module tick_sched import mpcd_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  tick_sched_if.slave  bus
);

  localparam int PW = ptr_width(N_REQ);

  state_t           state_r, state_s;
  logic [DW-1:0]    cnt_r, cnt_s;
  logic [PW-1:0]    ptr_r, ptr_s;
  logic [PW-1:0]    owner_r, owner_s;
  logic [PW-1:0]    ptr_inc_s;
  logic [PW-1:0]    idx_s;
  logic [N_REQ-1:0] sel_s;
  logic [N_REQ-1:0] gnt_r, gnt_s;
  logic [N_REQ-1:0] done_r, done_s;
  logic             busy_r, busy_s;
  logic [DW-1:0]    dly_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_dly
    assign dly_a[i] = bus.dly[i*DW +: DW];
  end

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req (bus.req),
    .ptr (ptr_r),
    .sel (sel_s),
    .idx (idx_s)
  );

  assign ptr_inc_s = (owner_r == PW'(N_REQ - 1)) ? {PW{1'b0}} : owner_r + PW'(1);

  // Next-state and next-output logic; cancel is tested before expiry so it wins.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    gnt_s   = gnt_r;
    done_s  = {N_REQ{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (|bus.req) begin
          state_s = ST_COUNT;
          gnt_s   = sel_s;
          owner_s = idx_s;
          cnt_s   = dly_a[idx_s];
        end else begin
          gnt_s = {N_REQ{1'b0}};
        end
      end
      ST_COUNT: begin
        if (!bus.req[owner_r]) begin
          state_s = ST_IDLE;
          gnt_s   = {N_REQ{1'b0}};
          ptr_s   = ptr_inc_s;
        end else if ((cnt_r == DW'(0)) || (bus.tick && (cnt_r == DW'(1)))) begin
          state_s = ST_FIN;
          gnt_s   = {N_REQ{1'b0}};
          done_s  = gnt_r;
        end else if (bus.tick) begin
          cnt_s = cnt_r - DW'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
        ptr_s   = ptr_inc_s;
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = {N_REQ{1'b0}};
      end
    endcase
    busy_s = |gnt_s;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {DW{1'b0}};
      ptr_r   <= {PW{1'b0}};
      owner_r <= {PW{1'b0}};
      gnt_r   <= {N_REQ{1'b0}};
      done_r  <= {N_REQ{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ptr_r   <= ptr_s;
      owner_r <= owner_s;
      gnt_r   <= gnt_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboard bench for tick_sched: stimulus queues cycle-stamped expected
// events, a negedge monitor consumes them and flags anything unexpected.
module tb_tick_sched;

  localparam int EV_GNT  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_IDLE = 2;
  localparam int EV_BUSY = 3;

  typedef struct {
    int         kind;
    int         at;
    logic [3:0] val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  ev_t        exp_q[$];
  int         rd_idx = 0;
  bit         mon_en = 1'b0;
  bit         fin_req = 1'b0;
  bit         mon_done = 1'b0;
  logic [3:0] prev_gnt = 4'b0;
  ev_t        e;
  bit         g_seen;
  bit         d_seen;
  int         c;

  tick_sched_if #(.N_REQ(4), .DW(8)) tif ();

  tick_sched #(.N_REQ(4), .DW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int kind, input int at, input logic [3:0] val);
    ev_t ev;
    ev.kind = kind;
    ev.at   = at;
    ev.val  = val;
    exp_q.push_back(ev);
  endtask

  task automatic set_dly(input int i, input logic [7:0] v);
    tif.dly[i*8 +: 8] = v;
  endtask

  task automatic do_tick();
    tif.tick = 1'b1;
    step(1);
    tif.tick = 1'b0;
  endtask

  // Monitor: consume due expectations, then police unexpected grants/dones.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      g_seen = 1'b0;
      d_seen = 1'b0;
      while (rd_idx < exp_q.size() && exp_q[rd_idx].at <= cyc) begin
        e = exp_q[rd_idx];
        rd_idx = rd_idx + 1;
        n_cmp = n_cmp + 1;
        if (e.at < cyc) begin
          n_err = n_err + 1;
          $display("FAIL missed_event kind=%0d: due cycle %0d, now cycle %0d", e.kind, e.at, cyc);
        end else begin
          case (e.kind)
            EV_GNT: begin
              g_seen = 1'b1;
              if (tif.gnt !== e.val) begin
                n_err = n_err + 1;
                $display("FAIL gnt @%0d: got %b, want %b", cyc, tif.gnt, e.val);
              end
            end
            EV_DONE: begin
              d_seen = 1'b1;
              if (tif.done !== e.val) begin
                n_err = n_err + 1;
                $display("FAIL done @%0d: got %b, want %b", cyc, tif.done, e.val);
              end
            end
            EV_IDLE: begin
              if ({tif.gnt, tif.done, tif.busy} !== 9'b0) begin
                n_err = n_err + 1;
                $display("FAIL idle @%0d: got gnt=%b done=%b busy=%b, want all 0", cyc, tif.gnt, tif.done, tif.busy);
              end
            end
            EV_BUSY: begin
              if (tif.busy !== e.val[0]) begin
                n_err = n_err + 1;
                $display("FAIL busy @%0d: got %b, want %b", cyc, tif.busy, e.val[0]);
              end
            end
            default: begin
              n_err = n_err + 1;
              $display("FAIL bad_event kind=%0d", e.kind);
            end
          endcase
        end
      end
      if (tif.gnt !== prev_gnt && tif.gnt !== 4'b0 && !g_seen) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_gnt @%0d: got %b, want no new grant", cyc, tif.gnt);
      end
      if (tif.done !== 4'b0 && !d_seen) begin
        n_cmp = n_cmp + 1;
        n_err = n_err + 1;
        $display("FAIL unexpected_done @%0d: got %b, want 0000", cyc, tif.done);
      end
      if (tif.done !== 4'b0) begin
        n_cmp = n_cmp + 1;
        if (tif.gnt !== 4'b0 || tif.done !== prev_gnt) begin
          n_err = n_err + 1;
          $display("FAIL done_rule @%0d: got gnt=%b done=%b prev_gnt=%b, want gnt=0 and done=prev_gnt",
                   cyc, tif.gnt, tif.done, prev_gnt);
        end
      end
      if (fin_req && !mon_done) begin
        n_cmp = n_cmp + 1;
        if (rd_idx != exp_q.size()) begin
          n_err = n_err + 1;
          $display("FAIL leftover_events: got %0d consumed, want %0d", rd_idx, exp_q.size());
        end
        mon_done = 1'b1;
      end
    end
    prev_gnt = tif.gnt;
  end

  initial begin
    rst_n    = 1'b0;
    tif.tick = 1'b0;
    tif.req  = 4'b0;
    tif.dly  = 32'b0;
    step(1);
    mon_en = 1'b1;
    expect_ev(EV_IDLE, cyc + 1, 4'b0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Single requester, delay 3: DONE on the third tick after grant.
    c = cyc;
    tif.req = 4'b0001;
    set_dly(0, 8'd3);
    expect_ev(EV_GNT, c + 1, 4'b0001);
    step(1);
    expect_ev(EV_BUSY, cyc, 4'b0001);
    step(3);
    do_tick();
    step(4);
    do_tick();
    step(6);
    expect_ev(EV_DONE, cyc + 1, 4'b0001);
    do_tick();
    tif.req = 4'b0000;
    step(2);

    // Zero delay: DONE one cycle after GNT, no tick needed.
    c = cyc;
    tif.req = 4'b0100;
    set_dly(2, 8'd0);
    expect_ev(EV_GNT,  c + 1, 4'b0100);
    expect_ev(EV_BUSY, c + 1, 4'b0001);
    expect_ev(EV_DONE, c + 2, 4'b0100);
    expect_ev(EV_IDLE, c + 3, 4'b0);
    step(2);
    tif.req = 4'b0000;
    step(3);

    // Cancel of requester 1 after two ticks; pending 3 wins over 0 (ptr = 2).
    c = cyc;
    tif.req = 4'b0010;
    set_dly(1, 8'd5);
    set_dly(3, 8'd0);
    set_dly(0, 8'd0);
    expect_ev(EV_GNT, c + 1, 4'b0010);
    step(1);
    tif.req = 4'b1011;
    step(2);
    do_tick();
    step(2);
    do_tick();
    step(2);
    c = cyc;
    tif.req = 4'b1001;
    expect_ev(EV_IDLE, c + 1, 4'b0);
    expect_ev(EV_GNT,  c + 2, 4'b1000);
    expect_ev(EV_DONE, c + 3, 4'b1000);
    step(3);
    tif.req = 4'b0000;
    step(2);

    // All four held, delay 1: grants rotate 0,1,2,3,0 with one DONE each.
    for (int i = 0; i < 4; i++) set_dly(i, 8'd1);
    c = cyc;
    tif.req = 4'b1111;
    expect_ev(EV_GNT, c + 1, 4'b0001);
    step(1);
    for (int k = 0; k < 5; k++) begin
      step(2);
      expect_ev(EV_DONE, cyc + 1, 4'b0001 << (k % 4));
      do_tick();
      if (k < 4) begin
        expect_ev(EV_GNT, cyc + 2, 4'b0001 << ((k + 1) % 4));
        step(2);
      end else begin
        tif.req = 4'b0000;
        step(3);
      end
    end

    // Reset during COUNT with CNT = 4: no DONE, arbitration restarts at 0.
    c = cyc;
    tif.req = 4'b0010;
    set_dly(1, 8'd6);
    expect_ev(EV_GNT, c + 1, 4'b0010);
    step(3);
    do_tick();
    step(2);
    do_tick();
    step(2);
    rst_n = 1'b0;
    step(1);
    expect_ev(EV_IDLE, cyc, 4'b0);
    rst_n = 1'b1;
    tif.req = 4'b1001;
    set_dly(0, 8'd0);
    set_dly(3, 8'd0);
    expect_ev(EV_GNT,  cyc + 1, 4'b0001);
    expect_ev(EV_DONE, cyc + 2, 4'b0001);
    step(2);
    tif.req = 4'b0000;
    step(3);

    // Drop REQ in the same cycle as the expiring tick: cancel wins.
    c = cyc;
    tif.req = 4'b0100;
    set_dly(2, 8'd1);
    expect_ev(EV_GNT, c + 1, 4'b0100);
    step(3);
    tif.tick = 1'b1;
    tif.req  = 4'b0000;
    step(1);
    tif.tick = 1'b0;
    expect_ev(EV_IDLE, cyc, 4'b0);
    tif.req = 4'b0001;
    set_dly(0, 8'd0);
    expect_ev(EV_GNT,  cyc + 1, 4'b0001);
    expect_ev(EV_DONE, cyc + 2, 4'b0001);
    step(2);
    tif.req = 4'b0000;
    step(3);

    fin_req = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) step(1);
    if (!mon_done) begin
      $display("FAIL monitor_timeout: monitor did not finish within 10 cycles");
      $fatal(1, "monitor timeout");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
